// File: rtl/kcpu_irq_pkg.sv
// Shared types, config register map and helpers for the KCPU interrupt controller.
package kcpu_irq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } irqState_t;

  localparam logic [1:0] CFG_MASK = 2'd0;
  localparam logic [1:0] CFG_EDGE = 2'd1;
  localparam logic [1:0] CFG_PRIO = 2'd2;
  localparam logic [1:0] CFG_PEND = 2'd3;

  localparam int unsigned CFG_W = 32;

  // Index width that stays legal for a single-channel build.
  function automatic int unsigned idxWidth(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_priority_arbiter.sv
// Combinational priority arbiter: highest priority among eligible channels, ties to lowest index.
module irq_priority_arbiter
  import kcpu_irq_pkg::*;
#(
  parameter int unsigned N_SRC  = 8,
  parameter int unsigned PRIO_W = 2
) (
  input  logic [N_SRC-1:0]          eligible,
  input  logic [N_SRC*PRIO_W-1:0]   prio,
  output logic                      valid,
  output logic [idxWidth(N_SRC)-1:0] winner
);

  localparam int unsigned IDX_W = idxWidth(N_SRC);

  logic [PRIO_W-1:0] bestPrio;

  // Strict greater-than keeps the earliest (lowest) index on ties.
  always_comb begin
    valid    = 1'b0;
    winner   = '0;
    bestPrio = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (eligible[i] && (!valid || (prio[i*PRIO_W +: PRIO_W] > bestPrio))) begin
        valid    = 1'b1;
        winner   = IDX_W'(i);
        bestPrio = prio[i*PRIO_W +: PRIO_W];
      end
    end
  end

endmodule

// File: rtl/kcpu_irq_controller.sv
// Multi-source interrupt controller: pending capture, mask/priority arbitration and
// a 4-phase irIrq/irResponse handshake towards the KCPU core.
module kcpu_irq_controller
  import kcpu_irq_pkg::*;
#(
  parameter int unsigned N_SRC  = 8,
  parameter int unsigned DATA_W = 4,
  parameter int unsigned PRIO_W = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_SRC-1:0]            srcReq,
  input  logic [N_SRC*DATA_W-1:0]     srcData,
  output logic [N_SRC-1:0]            srcAck,
  input  logic                        cfgWE,
  input  logic [1:0]                  cfgAddr,
  input  logic [CFG_W-1:0]            cfgWData,
  output logic [CFG_W-1:0]            cfgRData,
  output logic                        irIrq,
  output logic [DATA_W-1:0]           irData,
  output logic [idxWidth(N_SRC)-1:0]  irSrc,
  input  logic                        irResponse
);

  localparam int unsigned SRC_W  = idxWidth(N_SRC);
  localparam int unsigned PRIO_T = N_SRC * PRIO_W;

  irqState_t state, stateNext;

  logic [N_SRC-1:0]  maskReg, edgeReg, pendReg, reqPrev;
  logic [PRIO_T-1:0] prioReg;

  logic [N_SRC-1:0]  setVec, cfgClr, ackClr, eligible, grantOneHot, srcAckNext;
  logic              arbValid, irIrqNext;
  logic [SRC_W-1:0]  arbWinner, irSrcNext;
  logic [DATA_W-1:0] winData, irDataNext;
  logic              unusedCfg;

  assign unusedCfg = ^cfgWData;

  // Edge channels fire on a rising request, level channels whenever high.
  assign setVec   = srcReq & (~edgeReg | ~reqPrev);
  assign cfgClr   = (cfgWE && (cfgAddr == CFG_PEND)) ? cfgWData[N_SRC-1:0] : '0;
  assign eligible = pendReg & maskReg;

  irq_priority_arbiter #(
    .N_SRC  (N_SRC),
    .PRIO_W (PRIO_W)
  ) u_arb (
    .eligible (eligible),
    .prio     (prioReg),
    .valid    (arbValid),
    .winner   (arbWinner)
  );

  always_comb begin
    winData = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (arbWinner == SRC_W'(i)) winData = srcData[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    grantOneHot = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      grantOneHot[i] = (irSrc == SRC_W'(i));
    end
  end

  // Next-state and next-output logic of the handshake FSM.
  always_comb begin
    stateNext  = state;
    irIrqNext  = irIrq;
    irDataNext = irData;
    irSrcNext  = irSrc;
    srcAckNext = '0;
    ackClr     = '0;
    unique case (state)
      IDLE: begin
        if (arbValid) begin
          stateNext  = GRANT;
          irIrqNext  = 1'b1;
          irDataNext = winData;
          irSrcNext  = arbWinner;
        end
      end
      GRANT: begin
        if (irResponse) begin
          stateNext  = ACK;
          irIrqNext  = 1'b0;
          srcAckNext = grantOneHot;
          ackClr     = grantOneHot;
        end
      end
      ACK: begin
        if (!irResponse) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      irIrq  <= 1'b0;
      irData <= '0;
      irSrc  <= '0;
      srcAck <= '0;
    end else begin
      state  <= stateNext;
      irIrq  <= irIrqNext;
      irData <= irDataNext;
      irSrc  <= irSrcNext;
      srcAck <= srcAckNext;
    end
  end

  // New requests win over acknowledge and W1C clears in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pendReg <= '0;
      reqPrev <= '0;
    end else begin
      pendReg <= (pendReg & ~(ackClr | cfgClr)) | setVec;
      reqPrev <= srcReq;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      maskReg <= '0;
      edgeReg <= '0;
      prioReg <= '0;
    end else if (cfgWE) begin
      case (cfgAddr)
        CFG_MASK: maskReg <= cfgWData[N_SRC-1:0];
        CFG_EDGE: edgeReg <= cfgWData[N_SRC-1:0];
        CFG_PRIO: prioReg <= cfgWData[PRIO_T-1:0];
        default:  ;
      endcase
    end
  end

  always_comb begin
    cfgRData = '0;
    case (cfgAddr)
      CFG_MASK: cfgRData[N_SRC-1:0]  = maskReg;
      CFG_EDGE: cfgRData[N_SRC-1:0]  = edgeReg;
      CFG_PRIO: cfgRData[PRIO_T-1:0] = prioReg;
      default:  cfgRData[N_SRC-1:0]  = pendReg;
    endcase
  end

endmodule

// File: tb/tb_kcpu_irq_controller.sv
// Directed bench for kcpu_irq_controller: arbitration vector table plus handshake corner sequences.
module tb_kcpu_irq_controller;
  import kcpu_irq_pkg::*;

  localparam int unsigned N_SRC  = 8;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned PRIO_W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  srcReq;
  logic [31:0] srcData;
  logic [7:0]  srcAck;
  logic        cfgWE;
  logic [1:0]  cfgAddr;
  logic [31:0] cfgWData;
  logic [31:0] cfgRData;
  logic        irIrq;
  logic [3:0]  irData;
  logic [2:0]  irSrc;
  logic        irResponse;

  always #5 clk = ~clk;

  kcpu_irq_controller #(
    .N_SRC  (N_SRC),
    .DATA_W (DATA_W),
    .PRIO_W (PRIO_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .srcReq     (srcReq),
    .srcData    (srcData),
    .srcAck     (srcAck),
    .cfgWE      (cfgWE),
    .cfgAddr    (cfgAddr),
    .cfgWData   (cfgWData),
    .cfgRData   (cfgRData),
    .irIrq      (irIrq),
    .irData     (irData),
    .irSrc      (irSrc),
    .irResponse (irResponse)
  );

  typedef struct {
    logic [7:0]  mask;
    logic [7:0]  edgeM;
    logic [15:0] prio;
    logic [7:0]  req;
    logic [31:0] data;
    int          nGrant;
    int          src0;
    logic [3:0]  dat0;
    int          src1;
    logic [3:0]  dat1;
    logic [7:0]  pendAfter;
  } vec_t;

  vec_t vecs [6];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfgWrite(input logic [1:0] a, input logic [31:0] d);
    cfgWE    = 1'b1;
    cfgAddr  = a;
    cfgWData = d;
    step();
    cfgWE    = 1'b0;
    cfgAddr  = CFG_PEND;
    cfgWData = '0;
  endtask

  task automatic checkReg(input string name, input logic [1:0] a, input logic [31:0] exp);
    cfgAddr = a;
    #1;
    check(name, cfgRData, exp);
    cfgAddr = CFG_PEND;
  endtask

  task automatic waitIrq(input int maxCyc, output int cyc);
    cyc = 0;
    while (irIrq !== 1'b1 && cyc < maxCyc) begin
      step();
      cyc++;
    end
  endtask

  // Full 4-phase handshake for the currently granted channel; returns in IDLE.
  task automatic handshake(input int src, input string tag);
    logic [7:0] expAck;
    expAck = 8'(1) << src;
    irResponse = 1'b1;
    step();
    check({tag, "_ack"}, 32'(srcAck), 32'(expAck));
    check({tag, "_irq_drop"}, 32'(irIrq), 32'(0));
    step();
    check({tag, "_ack_pulse"}, 32'(srcAck), 32'(0));
    irResponse = 1'b0;
    step();
  endtask

  task automatic runVec(input vec_t v, input int idx);
    int cyc;
    cfgWrite(CFG_PEND, 32'hFFFF_FFFF);
    cfgWrite(CFG_EDGE, 32'(v.edgeM));
    cfgWrite(CFG_PRIO, 32'(v.prio));
    cfgWrite(CFG_MASK, 32'(v.mask));
    srcData = v.data;
    srcReq  = v.req;
    step();
    check($sformatf("v%0d_lat1", idx), 32'(irIrq), 32'(0));
    srcReq = '0;
    step();
    check($sformatf("v%0d_lat2", idx), 32'(irIrq), 32'(1));
    check($sformatf("v%0d_src0", idx), 32'(irSrc), 32'(v.src0));
    check($sformatf("v%0d_dat0", idx), 32'(irData), 32'(v.dat0));
    handshake(v.src0, $sformatf("v%0d_g0", idx));
    if (v.nGrant > 1) begin
      waitIrq(4, cyc);
      check($sformatf("v%0d_irq1", idx), 32'(irIrq), 32'(1));
      check($sformatf("v%0d_src1", idx), 32'(irSrc), 32'(v.src1));
      check($sformatf("v%0d_dat1", idx), 32'(irData), 32'(v.dat1));
      handshake(v.src1, $sformatf("v%0d_g1", idx));
    end
    checkReg($sformatf("v%0d_pend", idx), CFG_PEND, 32'(v.pendAfter));
  endtask

  initial begin
    //          mask   edge   prio      req    data          n  s0 d0     s1 d1     pend
    vecs[0] = '{8'hFF, 8'h08, 16'h0000, 8'h08, 32'h0000_A000, 1, 3, 4'hA, 0, 4'h0, 8'h00};
    vecs[1] = '{8'hFF, 8'h42, 16'h3004, 8'h42, 32'h0C00_0050, 2, 6, 4'hC, 1, 4'h5, 8'h00};
    vecs[2] = '{8'h24, 8'h00, 16'h0820, 8'h24, 32'h0090_0700, 2, 2, 4'h7, 5, 4'h9, 8'h00};
    vecs[3] = '{8'h0F, 8'h00, 16'hC000, 8'h81, 32'hE000_0006, 1, 0, 4'h6, 0, 4'h0, 8'h80};
    vecs[4] = '{8'hFF, 8'h81, 16'h0000, 8'h81, 32'hF000_0001, 2, 0, 4'h1, 7, 4'hF, 8'h00};
    vecs[5] = '{8'hFF, 8'h00, 16'h0240, 8'h18, 32'h0004_3000, 2, 4, 4'h4, 3, 4'h3, 8'h00};

    rst = 1'b0; srcReq = '0; srcData = '0; cfgWE = 1'b0; cfgAddr = CFG_PEND;
    cfgWData = '0; irResponse = 1'b0;
    step(); step();
    check("rst_irq", 32'(irIrq), 32'(0));
    check("rst_ack", 32'(srcAck), 32'(0));
    check("rst_src", 32'(irSrc), 32'(0));
    checkReg("rst_pend", CFG_PEND, 32'(0));
    checkReg("rst_mask", CFG_MASK, 32'(0));
    rst = 1'b1;
    step();

    // Register width and readback.
    cfgWrite(CFG_MASK, 32'hFFFF_FFFF);
    checkReg("rd_mask", CFG_MASK, 32'h0000_00FF);
    cfgWrite(CFG_PRIO, 32'hFFFF_FFFF);
    checkReg("rd_prio", CFG_PRIO, 32'h0000_FFFF);
    cfgWrite(CFG_EDGE, 32'hFFFF_0F0F);
    checkReg("rd_edge", CFG_EDGE, 32'h0000_000F);
    cfgWrite(CFG_MASK, 32'h0);

    for (int i = 0; i < 6; i++) runVec(vecs[i], i);

    // New edge on ch0 in the same cycle as its acknowledge clear.
    cfgWrite(CFG_PEND, 32'hFF);
    cfgWrite(CFG_EDGE, 32'h01);
    cfgWrite(CFG_PRIO, 32'h0);
    cfgWrite(CFG_MASK, 32'hFF);
    srcData = 32'h0000_000B;
    srcReq = 8'h01; step(); srcReq = '0; step();
    check("s4_grant", 32'(irIrq), 32'(1));
    check("s4_src", 32'(irSrc), 32'(0));
    irResponse = 1'b1; srcReq = 8'h01;
    step();
    check("s4_ack", 32'(srcAck), 32'h01);
    checkReg("s4_pend_kept", CFG_PEND, 32'h01);
    srcReq = '0;
    step();
    irResponse = 1'b0;
    step();
    check("s4_idle_gap", 32'(irIrq), 32'(0));
    step();
    check("s4_regrant", 32'(irIrq), 32'(1));
    check("s4_regrant_src", 32'(irSrc), 32'(0));
    handshake(0, "s4");
    checkReg("s4_pend_end", CFG_PEND, 32'(0));

    // Masked pending channel, late unmask, W1C before grant, set-vs-W1C.
    cfgWrite(CFG_MASK, 32'hEF);
    cfgWrite(CFG_EDGE, 32'h0);
    srcData = 32'h0005_0000;
    srcReq = 8'h10; step(); srcReq = '0;
    step(); step(); step();
    check("s5_masked", 32'(irIrq), 32'(0));
    checkReg("s5_pend", CFG_PEND, 32'h10);
    cfgWrite(CFG_MASK, 32'hFF);
    check("s5_unmask_n", 32'(irIrq), 32'(0));
    step();
    check("s5_unmask_n1", 32'(irIrq), 32'(1));
    check("s5_src", 32'(irSrc), 32'(4));
    check("s5_dat", 32'(irData), 32'(5));
    handshake(4, "s5");
    cfgWrite(CFG_MASK, 32'hEF);
    srcReq = 8'h10; step(); srcReq = '0;
    cfgWrite(CFG_PEND, 32'h10);
    cfgWrite(CFG_MASK, 32'hFF);
    step(); step();
    check("s5_w1c_noirq", 32'(irIrq), 32'(0));
    checkReg("s5_w1c_pend", CFG_PEND, 32'(0));
    cfgWrite(CFG_MASK, 32'h0);
    cfgWrite(CFG_EDGE, 32'h02);
    srcReq = 8'h02;
    cfgWrite(CFG_PEND, 32'h02);
    checkReg("s5_set_wins", CFG_PEND, 32'h02);
    cfgWrite(CFG_PEND, 32'h02);
    checkReg("s5_w1c_clear", CFG_PEND, 32'(0));
    srcReq = '0;

    // Level ch7 held high through a long acknowledge.
    cfgWrite(CFG_EDGE, 32'h0);
    cfgWrite(CFG_PRIO, 32'h0);
    cfgWrite(CFG_MASK, 32'h80);
    srcData = 32'h7000_0000;
    srcReq = 8'h80; step();
    check("s6_lat1", 32'(irIrq), 32'(0));
    step();
    check("s6_grant", 32'(irIrq), 32'(1));
    check("s6_src", 32'(irSrc), 32'(7));
    check("s6_dat", 32'(irData), 32'(7));
    irResponse = 1'b1;
    step();
    check("s6_ack", 32'(srcAck), 32'h80);
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("s6_hold%0d", k), 32'(irIrq), 32'(0));
    end
    irResponse = 1'b0;
    step();
    check("s6_idle_gap", 32'(irIrq), 32'(0));
    step();
    check("s6_regrant", 32'(irIrq), 32'(1));
    check("s6_regrant_src", 32'(irSrc), 32'(7));
    srcReq = '0;
    handshake(7, "s6");
    checkReg("s6_pend_end", CFG_PEND, 32'(0));

    // Asynchronous reset in the middle of a grant.
    cfgWrite(CFG_MASK, 32'hFF);
    srcData = 32'h0000_0D00;
    srcReq = 8'h04; step(); srcReq = '0; step();
    check("s1_grant", 32'(irIrq), 32'(1));
    check("s1_src", 32'(irSrc), 32'(2));
    #2 rst = 1'b0;
    #1;
    check("s1_irq", 32'(irIrq), 32'(0));
    check("s1_ack", 32'(srcAck), 32'(0));
    check("s1_dat", 32'(irData), 32'(0));
    checkReg("s1_pend", CFG_PEND, 32'(0));
    checkReg("s1_mask", CFG_MASK, 32'(0));
    step();
    rst = 1'b1;
    irResponse = 1'b1;
    step(); step();
    check("s1_no_ack", 32'(srcAck), 32'(0));
    check("s1_no_irq", 32'(irIrq), 32'(0));
    irResponse = 1'b0;
    cfgWrite(CFG_MASK, 32'hFF);
    srcData = 32'h0000_0009;
    srcReq = 8'h01; step(); srcReq = '0; step();
    check("s1_idle_grant", 32'(irIrq), 32'(1));
    check("s1_idle_dat", 32'(irData), 32'(9));
    handshake(0, "s1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
